// File: rtl/iobus_arbiter.sv
// Round-robin arbiter that shares the MMIO IOBUS between the MCU load/store
// master (M0) and the debug/DMA master (M1), sequencing one transaction at a time.
module iobus_arbiter #(
  parameter int NUM_WAIT = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        M0_REQ,
  input  logic        M0_WR,
  input  logic [31:0] M0_ADDR,
  input  logic [31:0] M0_WDATA,
  output logic        M0_GNT,
  output logic        M0_DONE,
  output logic [31:0] M0_RDATA,
  input  logic        M1_REQ,
  input  logic        M1_WR,
  input  logic [31:0] M1_ADDR,
  input  logic [31:0] M1_WDATA,
  output logic        M1_GNT,
  output logic        M1_DONE,
  output logic [31:0] M1_RDATA,
  output logic [31:0] IOBUS_ADDR,
  output logic [31:0] IOBUS_OUT,
  output logic        IOBUS_WR,
  input  logic [31:0] IOBUS_IN,
  output logic        BUSY
);

  localparam int WCW = (NUM_WAIT < 1) ? 1 : $clog2(NUM_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(NUM_WAIT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t         state_r;
  state_t         next_state_s;
  logic           owner_r;       // 1'b0 = M0, 1'b1 = M1
  logic           last_owner_r;
  logic           wr_r;
  logic [WCW-1:0] wait_cnt_r;
  logic [31:0]    addr_r;
  logic [31:0]    out_r;
  logic [31:0]    rdata0_r;
  logic [31:0]    rdata1_r;
  logic           start_s;
  logic           pick_s;
  logic           last_access_s;

  // Next-state decode and round-robin pick; a tie goes to the master that did not own last.
  always_comb begin
    next_state_s  = state_r;
    start_s       = 1'b0;
    pick_s        = owner_r;
    last_access_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (M0_REQ && M1_REQ) begin
          start_s      = 1'b1;
          pick_s       = ~last_owner_r;
          next_state_s = ST_ACCESS;
        end else if (M0_REQ) begin
          start_s      = 1'b1;
          pick_s       = 1'b0;
          next_state_s = ST_ACCESS;
        end else if (M1_REQ) begin
          start_s      = 1'b1;
          pick_s       = 1'b1;
          next_state_s = ST_ACCESS;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (wr_r || (wait_cnt_r == WAIT_LAST)) begin
          last_access_s = 1'b1;
          next_state_s  = ST_DONE;
        end else begin
          next_state_s  = ST_ACCESS;
        end
      end
      ST_DONE: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State, ownership, bus registers and read-data capture.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r      <= ST_IDLE;
      owner_r      <= 1'b0;
      last_owner_r <= 1'b1;
      wr_r         <= 1'b0;
      wait_cnt_r   <= '0;
      addr_r       <= 32'h0000_0000;
      out_r        <= 32'h0000_0000;
      rdata0_r     <= 32'h0000_0000;
      rdata1_r     <= 32'h0000_0000;
    end else begin
      state_r <= next_state_s;
      if (start_s) begin
        owner_r      <= pick_s;
        last_owner_r <= pick_s;
        wr_r         <= pick_s ? M1_WR    : M0_WR;
        addr_r       <= pick_s ? M1_ADDR  : M0_ADDR;
        out_r        <= pick_s ? M1_WDATA : M0_WDATA;
        wait_cnt_r   <= '0;
      end else if (state_r == ST_ACCESS) begin
        if (last_access_s) begin
          // Bus returns to zero for the DONE cycle; only the owner's read data moves.
          addr_r <= 32'h0000_0000;
          out_r  <= 32'h0000_0000;
          if (!wr_r && !owner_r) rdata0_r <= IOBUS_IN;
          if (!wr_r &&  owner_r) rdata1_r <= IOBUS_IN;
        end else begin
          wait_cnt_r <= wait_cnt_r + WCW'(1);
        end
      end
    end
  end

  assign BUSY       = (state_r != ST_IDLE);
  assign M0_GNT     = BUSY && !owner_r;
  assign M1_GNT     = BUSY &&  owner_r;
  assign M0_DONE    = (state_r == ST_DONE) && !owner_r;
  assign M1_DONE    = (state_r == ST_DONE) &&  owner_r;
  assign IOBUS_WR   = (state_r == ST_ACCESS) && wr_r;
  assign IOBUS_ADDR = addr_r;
  assign IOBUS_OUT  = out_r;
  assign M0_RDATA   = rdata0_r;
  assign M1_RDATA   = rdata1_r;

endmodule

// File: tb/tb_iobus_arbiter.sv
// Bench for iobus_arbiter: directed scenarios then random two-master traffic,
// checked every cycle against a transaction-timeline reference model.
module tb_iobus_arbiter;

  localparam logic [31:0] LEDS = 32'h1108_0000;
  localparam logic [31:0] SSEG = 32'h110C_0000;
  localparam logic [31:0] SWA  = 32'h1100_0000;
  localparam int NW = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req [2];
  logic        wr  [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic        gnt0, gnt1, done0, done1, io_wr, busy;
  logic [31:0] rdata0, rdata1, io_addr, io_out, io_in;
  logic [31:0] sw_val, leds;

  logic        z_req;
  logic [31:0] z_addr;
  logic        z_gnt0, z_gnt1, z_done0, z_done1, z_io_wr, z_busy;
  logic [31:0] z_rdata0, z_rdata1, z_io_addr, z_io_out, z_io_in;

  function automatic logic [31:0] periph(input logic [31:0] a, input logic [31:0] sw);
    return (a == SWA) ? sw : (a ^ 32'hC3C3_0F0F);
  endfunction

  assign io_in   = periph(io_addr, sw_val);
  assign z_io_in = periph(z_io_addr, sw_val);

  always @(posedge clk) begin
    if (rst) leds <= 32'h0;
    else if (io_wr && io_addr == LEDS) leds <= io_out;
  end

  iobus_arbiter #(.NUM_WAIT(NW)) u_dut (
    .CLK(clk), .RST(rst),
    .M0_REQ(req[0]), .M0_WR(wr[0]), .M0_ADDR(addr[0]), .M0_WDATA(wdata[0]),
    .M0_GNT(gnt0), .M0_DONE(done0), .M0_RDATA(rdata0),
    .M1_REQ(req[1]), .M1_WR(wr[1]), .M1_ADDR(addr[1]), .M1_WDATA(wdata[1]),
    .M1_GNT(gnt1), .M1_DONE(done1), .M1_RDATA(rdata1),
    .IOBUS_ADDR(io_addr), .IOBUS_OUT(io_out), .IOBUS_WR(io_wr), .IOBUS_IN(io_in),
    .BUSY(busy)
  );

  iobus_arbiter #(.NUM_WAIT(0)) u_dut_nw0 (
    .CLK(clk), .RST(rst),
    .M0_REQ(z_req), .M0_WR(1'b0), .M0_ADDR(z_addr), .M0_WDATA(32'h0),
    .M0_GNT(z_gnt0), .M0_DONE(z_done0), .M0_RDATA(z_rdata0),
    .M1_REQ(1'b0), .M1_WR(1'b0), .M1_ADDR(32'h0), .M1_WDATA(32'h0),
    .M1_GNT(z_gnt1), .M1_DONE(z_done1), .M1_RDATA(z_rdata1),
    .IOBUS_ADDR(z_io_addr), .IOBUS_OUT(z_io_out), .IOBUS_WR(z_io_wr), .IOBUS_IN(z_io_in),
    .BUSY(z_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a granted transaction occupies cycles k=1..len, DONE at k==len.
  bit          m_busy;
  int          m_k, m_len, m_owner, m_last;
  bit          m_wr;
  logic [31:0] m_addr, m_data;
  logic [31:0] m_rdata [2];

  task automatic model_step();
    if (rst) begin
      m_busy = 1'b0; m_last = 1; m_k = 0;
      m_rdata[0] = 32'h0; m_rdata[1] = 32'h0;
    end else if (m_busy) begin
      if (m_k == m_len) m_busy = 1'b0;
      else begin
        if (!m_wr && m_k == m_len - 1) m_rdata[m_owner] = periph(m_addr, sw_val);
        m_k++;
      end
    end else if (req[0] || req[1]) begin
      m_owner = (req[0] && req[1]) ? 1 - m_last : (req[0] ? 0 : 1);
      m_last  = m_owner;
      m_busy  = 1'b1;
      m_k     = 1;
      m_wr    = wr[m_owner];
      m_addr  = addr[m_owner];
      m_data  = wdata[m_owner];
      m_len   = m_wr ? 2 : NW + 2;
    end
  endtask

  task automatic compare_all();
    bit acc, dn;
    acc = m_busy && (m_k < m_len);
    dn  = m_busy && (m_k == m_len);
    check_val("gnt0",    32'(gnt0),    32'(m_busy && m_owner == 0));
    check_val("gnt1",    32'(gnt1),    32'(m_busy && m_owner == 1));
    check_val("gnt_excl", 32'(gnt0 & gnt1), 32'h0);
    check_val("done0",   32'(done0),   32'(dn && m_owner == 0));
    check_val("done1",   32'(done1),   32'(dn && m_owner == 1));
    check_val("busy",    32'(busy),    32'(m_busy));
    check_val("io_wr",   32'(io_wr),   32'(acc && m_wr));
    check_val("io_addr", io_addr,      acc ? m_addr : 32'h0);
    check_val("io_out",  io_out,       acc ? m_data : 32'h0);
    check_val("rdata0",  rdata0,       m_rdata[0]);
    check_val("rdata1",  rdata1,       m_rdata[1]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic new_txn(input int i);
    wr[i] = 1'($urandom % 2);
    case ($urandom % 4)
      0:       addr[i] = LEDS;
      1:       addr[i] = SSEG;
      2:       addr[i] = SWA;
      default: addr[i] = $urandom;
    endcase
    wdata[i] = $urandom;
    req[i]   = 1'b1;
  endtask

  bit pend [2];
  int seen;

  initial begin
    rst = 1'b1; sw_val = 32'h0; z_req = 1'b0; z_addr = 32'h0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; wr[i] = 1'b0; addr[i] = 32'h0; wdata[i] = 32'h0; pend[i] = 1'b0;
    end
    m_busy = 1'b0; m_k = 0; m_len = 2; m_owner = 0; m_last = 1; m_wr = 1'b0;
    m_addr = 32'h0; m_data = 32'h0; m_rdata[0] = 32'h0; m_rdata[1] = 32'h0;
    tick(); tick();
    check_val("reset_nw0_busy", 32'(z_busy), 32'h0);
    rst = 1'b0;

    // M0 write to LEDS
    req[0] = 1'b1; wr[0] = 1'b1; addr[0] = LEDS; wdata[0] = 32'h0000_A5A5;
    tick();
    check_val("t1_strobe", 32'(io_wr), 32'h1);
    tick();
    check_val("t1_done", 32'(done0), 32'h1);
    req[0] = 1'b0;
    tick();
    check_val("t1_leds", leds, 32'h0000_A5A5);
    check_val("t1_strobe_off", 32'(io_wr), 32'h0);

    // M1 read of SWITCHES
    sw_val = 32'h0000_1234;
    req[1] = 1'b1; wr[1] = 1'b0; addr[1] = SWA;
    tick(); tick();
    check_val("t2_addr_held", io_addr, SWA);
    tick();
    check_val("t2_done", 32'(done1), 32'h1);
    check_val("t2_rdata1", rdata1, 32'h0000_1234);
    check_val("t2_rdata0", rdata0, 32'h0);
    req[1] = 1'b0;
    tick();

    // Both held continuously: grants alternate starting with M0
    req[0] = 1'b1; wr[0] = 1'b1; addr[0] = LEDS; wdata[0] = 32'h0000_0001;
    req[1] = 1'b1; wr[1] = 1'b0; addr[1] = SSEG;
    seen = 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (done0 || done1) begin
        check_val("t3_order", 32'(done1), 32'(seen % 2));
        seen++;
      end
    end
    check_val("t3_grants", 32'(seen), 32'd5);
    req[0] = 1'b0; req[1] = 1'b0;
    tick();

    // M1 requests mid-way through an M0 read
    req[0] = 1'b1; wr[0] = 1'b0; addr[0] = SWA;
    tick();
    req[1] = 1'b1; wr[1] = 1'b1; addr[1] = LEDS; wdata[1] = 32'h0000_BEEF;
    tick();
    check_val("t4_m1_wait", 32'(gnt1), 32'h0);
    tick();
    check_val("t4_m0_done", 32'(done0), 32'h1);
    check_val("t4_m0_data", rdata0, 32'h0000_1234);
    req[0] = 1'b0;
    tick();
    check_val("t4_idle_gap", 32'(busy), 32'h0);
    tick();
    check_val("t4_m1_gnt", 32'(gnt1), 32'h1);
    tick();
    req[1] = 1'b0;
    tick();

    // Reset during the ACCESS cycle of an M1 write
    req[1] = 1'b1; wr[1] = 1'b1; addr[1] = SSEG; wdata[1] = 32'h0000_0077;
    tick();
    rst = 1'b1;
    tick();
    check_val("t5_no_done", 32'(done1), 32'h0);
    check_val("t5_idle", 32'(busy), 32'h0);
    rst = 1'b0;
    req[0] = 1'b1; wr[0] = 1'b0; addr[0] = SWA;
    tick();
    check_val("t5_m0_first", 32'(gnt0), 32'h1);
    req[0] = 1'b0; req[1] = 1'b0;
    for (int c = 0; c < 4; c++) tick();

    // NUM_WAIT=0 instance: single ACCESS cycle read
    sw_val = 32'h0000_55AA;
    z_req = 1'b1; z_addr = SWA;
    tick();
    check_val("t6_gnt", 32'(z_gnt0), 32'h1);
    check_val("t6_addr", z_io_addr, SWA);
    check_val("t6_no_wr", 32'(z_io_wr), 32'h0);
    tick();
    check_val("t6_done", 32'(z_done0), 32'h1);
    check_val("t6_data", z_rdata0, 32'h0000_55AA);
    check_val("t6_addr_clr", z_io_addr, 32'h0);
    z_req = 1'b0;
    tick();
    check_val("t6_idle", 32'(z_busy), 32'h0);

    // Random two-master traffic with occasional resets and mid-access REQ drops
    for (int c = 0; c < 3000; c++) begin
      sw_val = $urandom;
      if (rst) begin
        rst = 1'b0;
      end else if ($urandom % 300 == 0) begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin req[i] = 1'b0; pend[i] = 1'b0; end
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (m_busy && m_k == m_len && m_owner == i) begin
            pend[i] = 1'b0;
            if ($urandom % 2 == 0) begin new_txn(i); pend[i] = 1'b1; end
            else req[i] = 1'b0;
          end else if (!pend[i]) begin
            if ($urandom % 4 == 0) begin new_txn(i); pend[i] = 1'b1; end
          end else if (req[i] && m_busy && m_owner == i && m_k < m_len && $urandom % 6 == 0) begin
            req[i] = 1'b0;
          end
        end
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
